if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined RISC-V core.
- Owns the program counter and drives it as a combinational address into the instruction ROM, which returns a 32-bit word in the same cycle.
- Registers {pc, instruction} into the IF/ID pipeline register consumed by decode.
- Handles decode/execute stall, branch/jump redirect with bubble insertion, and halt on an all-zero word.

---
 rtl/if_stage_if.sv | 28 ++
 rtl/if_stage.sv | 91 +++++++++
 tb/tb_if_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-side bus: instruction ROM address/data plus the IF/ID pipeline register outputs.
// master = the fetch stage, slave = the ROM/decode side.
interface if_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic        id_pred_taken;

   modport master (
      output imem_addr,
      output id_pc,
      output id_instr,
      output id_valid,
      output id_pred_taken,
      input  imem_data
   );

   modport slave (
      input  imem_addr,
      input  id_pc,
      input  id_instr,
      input  id_valid,
      input  id_pred_taken,
      output imem_data
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a same-cycle ROM and fills IF/ID.
// Optional static backward-taken branch prediction under macro IF_STATIC_PREDICT_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_stall,
   input  logic         i_redirect,
   input  logic [31:0]  i_redirect_pc,
   if_stage_if.master   fetch_bus,
   output logic         o_halted,
   output logic [31:0]  o_fetch_count
);

   logic [31:0] r_pc;
   logic [31:0] r_id_pc;
   logic [31:0] r_id_instr;
   logic        r_id_valid;
   logic        r_id_pred_taken;
   logic        r_halted;
   logic [31:0] r_fetch_count;

   logic [31:0] w_instr;
   logic [31:0] w_seq_pc;
   logic [31:0] w_next_pc;
   logic        w_pred_taken;
   logic        w_zero_word;

   assign w_instr     = fetch_bus.imem_data;
   assign w_seq_pc    = r_pc + 32'd4;
   assign w_zero_word = (w_instr == 32'h0);

`ifdef IF_STATIC_PREDICT_EN
   logic        w_is_branch;
   logic [31:0] w_b_imm;

   // B-type immediate: {imm[12], imm[11], imm[10:5], imm[4:1], 0}, sign-extended.
   assign w_b_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                     w_instr[11:8], 1'b0};
   assign w_is_branch  = (w_instr[6:0] == 7'b1100011);
   assign w_pred_taken = w_is_branch && w_instr[31];
   assign w_next_pc    = w_pred_taken ? (r_pc + w_b_imm) : w_seq_pc;
`else
   assign w_pred_taken = 1'b0;
   assign w_next_pc    = w_seq_pc;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc            <= RESET_PC;
         r_id_pc         <= 32'd0;
         r_id_instr      <= NOP_INSTR;
         r_id_valid      <= 1'b0;
         r_id_pred_taken <= 1'b0;
         r_halted        <= 1'b0;
         r_fetch_count   <= 32'd0;
      end else if (i_redirect) begin
         // Redirect wins over stall and clears a halt; IF/ID becomes a bubble.
         r_pc            <= {i_redirect_pc[31:2], 2'b00};
         r_id_instr      <= NOP_INSTR;
         r_id_valid      <= 1'b0;
         r_id_pred_taken <= 1'b0;
         r_halted        <= 1'b0;
      end else if (r_halted || i_stall) begin
         // Hold everything; a halted stage already presents a bubble.
      end else if (w_zero_word) begin
         r_id_instr      <= NOP_INSTR;
         r_id_valid      <= 1'b0;
         r_id_pred_taken <= 1'b0;
         r_halted        <= 1'b1;
      end else begin
         r_pc            <= w_next_pc;
         r_id_pc         <= r_pc;
         r_id_instr      <= w_instr;
         r_id_valid      <= 1'b1;
         r_id_pred_taken <= w_pred_taken;
         r_fetch_count   <= r_fetch_count + 32'd1;
      end
   end

   assign fetch_bus.imem_addr     = r_pc;
   assign fetch_bus.id_pc         = r_id_pc;
   assign fetch_bus.id_instr      = r_id_instr;
   assign fetch_bus.id_valid      = r_id_valid;
   assign fetch_bus.id_pred_taken = r_id_pred_taken;
   assign o_halted                = r_halted;
   assign o_fetch_count           = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan sequence, then randomized
// stall/redirect/reset traffic against a behavioural fetch model.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halted;
   logic [31:0] fetch_count;

   logic [31:0] rom [0:63];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [31:0] m_pc, m_id_pc, m_id_instr, m_count;
   logic        m_id_valid, m_pred, m_halted;

   if_stage_if u_bus ();

   assign u_bus.imem_data = rom[u_bus.imem_addr[7:2]];

   if_stage #(
      .RESET_PC  (32'd0),
      .NOP_INSTR (NOP)
   ) u_dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .fetch_bus     (u_bus.master),
      .o_halted      (halted),
      .o_fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rom_word(input logic [31:0] addr);
      return rom[addr[7:2]];
   endfunction

   // Branch target from the B-type immediate fields, using plain arithmetic.
   function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] w);
      int off;
      off = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      return pc + 32'(off);
   endfunction

   function automatic logic [31:0] enc_branch(input int off);
      logic [12:0] imm;
      logic [4:0]  rs1, rs2;
      imm = 13'(off);
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic model_step();
      logic [31:0] w;
      logic        predict;
      w = rom_word(m_pc);
      if (rst) begin
         m_pc = 32'd0; m_id_pc = 32'd0; m_id_instr = NOP; m_id_valid = 1'b0;
         m_pred = 1'b0; m_halted = 1'b0; m_count = 32'd0;
      end else if (redirect) begin
         m_pc = redirect_pc & 32'hFFFF_FFFC;
         m_id_instr = NOP; m_id_valid = 1'b0; m_pred = 1'b0; m_halted = 1'b0;
      end else if (m_halted || stall) begin
         // nothing changes
      end else if (w == 32'h0) begin
         m_id_instr = NOP; m_id_valid = 1'b0; m_pred = 1'b0; m_halted = 1'b1;
      end else begin
`ifdef IF_STATIC_PREDICT_EN
         predict = (w[6:0] == 7'b1100011) && w[31];
`else
         predict = 1'b0;
`endif
         m_id_pc = m_pc; m_id_instr = w; m_id_valid = 1'b1; m_pred = predict;
         m_count = m_count + 32'd1;
         m_pc = predict ? branch_target(m_pc, w) : m_pc + 32'd4;
      end
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, ".imem_addr"}, u_bus.imem_addr, m_pc);
      check_eq({tag, ".id_pc"}, u_bus.id_pc, m_id_pc);
      check_eq({tag, ".id_instr"}, u_bus.id_instr, m_id_instr);
      check_eq({tag, ".id_valid"}, 32'(u_bus.id_valid), 32'(m_id_valid));
      check_eq({tag, ".id_pred"}, 32'(u_bus.id_pred_taken), 32'(m_pred));
      check_eq({tag, ".halted"}, 32'(halted), 32'(m_halted));
      check_eq({tag, ".fetch_count"}, fetch_count, m_count);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'h0;
      rom[0] = 32'h00a0_0513;
      rom[1] = 32'h0010_8093;
      rom[2] = 32'hfea0_cee3;
      rom[3] = 32'h0000_0000;
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

      // Reset held two cycles
      step("reset0");
      step("reset1");
      check_eq("tp1_addr", u_bus.imem_addr, 32'd0);
      check_eq("tp1_instr", u_bus.id_instr, NOP);
      rst = 1'b0;

      // Sequential fetch
      step("seq1");
      check_eq("tp2_instr1", u_bus.id_instr, 32'h00a0_0513);
      check_eq("tp2_addr1", u_bus.imem_addr, 32'd4);
      step("seq2");
      check_eq("tp2_pc2", u_bus.id_pc, 32'd4);
      check_eq("tp2_count", fetch_count, 32'd2);

      // Stall at pc=8
      stall = 1'b1;
      step("stall1");
      step("stall2");
      check_eq("tp3_addr_hold", u_bus.imem_addr, 32'd8);
      check_eq("tp3_count_hold", fetch_count, 32'd2);
      stall = 1'b0;
      step("stall_rel");
      check_eq("tp3_instr", u_bus.id_instr, 32'hfea0_cee3);
`ifdef IF_STATIC_PREDICT_EN
      check_eq("tp6_addr", u_bus.imem_addr, 32'd4);
      check_eq("tp6_pred", 32'(u_bus.id_pred_taken), 32'd1);
`else
      check_eq("tp6_addr", u_bus.imem_addr, 32'd12);
      check_eq("tp6_pred", 32'(u_bus.id_pred_taken), 32'd0);
`endif

      // Redirect during stall, unaligned target
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h6;
      step("redir_stall");
      check_eq("tp4_addr", u_bus.imem_addr, 32'd4);
      check_eq("tp4_valid", 32'(u_bus.id_valid), 32'd0);
      stall = 1'b0; redirect_pc = 32'd12;
      step("redir12");
      redirect = 1'b0;

      // Halt on zero word and recover
      step("halt");
      check_eq("tp5_halted", 32'(halted), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step("halt_hold");
         check_eq("tp5_addr_hold", u_bus.imem_addr, 32'd12);
      end
      redirect = 1'b1; redirect_pc = 32'd4;
      step("recover");
      check_eq("tp5_unhalt", 32'(halted), 32'd0);
      redirect = 1'b0;
      step("recover_fetch");
      check_eq("tp5_instr", u_bus.id_instr, 32'h0010_8093);

      // Randomized phase with a fresh ROM image
      for (int i = 0; i < 64; i++) begin
         case ($urandom_range(0, 9))
            0:       rom[i] = 32'h0;
            1, 2, 3: rom[i] = enc_branch(-4 * int'($urandom_range(1, 8)));
            4:       rom[i] = enc_branch(4 * int'($urandom_range(1, 8)));
            default: rom[i] = {$urandom_range(0, 32'h01FF_FFFF), 7'b0010011};
         endcase
      end
      for (int c = 0; c < 2000; c++) begin
         rst         = ($urandom_range(0, 99) < 2);
         stall       = ($urandom_range(0, 99) < 25);
         redirect    = ($urandom_range(0, 99) < 10);
         redirect_pc = $urandom_range(0, 255);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
